// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-to-AXI bridge.
// Contents: request type encodings, write FSM state enum, fixed AXI field
// values, and helpers that turn a request type into AXI len/size fields.
package cache_axi_pkg;

  localparam logic [2:0] T_BYTE = 3'd0;
  localparam logic [2:0] T_HALF = 3'd1;
  localparam logic [2:0] T_WORD = 3'd2;
  localparam logic [2:0] T_LINE = 3'd4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_e;

  // Line requests burst the whole line; everything else is a single beat.
  function automatic logic [7:0] req_len(input logic [2:0] t, input int unsigned line_words);
    if (t == T_LINE) begin
      req_len = 8'(line_words - 32'd1);
    end else begin
      req_len = 8'd0;
    end
  endfunction

  // Line beats are always full words; sub-line requests carry their size in type[1:0].
  function automatic logic [2:0] req_size(input logic [2:0] t);
    if (t == T_LINE) begin
      req_size = SIZE_WORD;
    end else begin
      req_size = {1'b0, t[1:0]};
    end
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// AXI3 master bus bundle used between the bridge and the memory side.
// Signals: ar*/r* read channels, aw*/w*/b* write channels, 4-bit IDs,
// 32-bit address/data. Modport master = bridge side, slave = memory side.
interface cache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_bridge_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr.
// Ports: req (N requests), ptr (search start) in; grant (one-hot),
// grant_idx (binary index of grant) and grant_vld (any grant) out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_vld
);

  // Scan N positions starting at ptr, wrapping, and keep the first hit.
  always_comb begin
    int idx_s;
    logic [PW-1:0] sel_s;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx_s     = 0;
    sel_s     = '0;
    for (int off = 0; off < N; off++) begin
      idx_s = int'(ptr) + off;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      sel_s = PW'(idx_s);
      if (!grant_vld && req[sel_s]) begin
        grant[sel_s] = 1'b1;
        grant_idx    = sel_s;
        grant_vld    = 1'b1;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI3 bridge for NUM_PORTS cache clients.
// Ports: clk, reset (async, active-high); per-client read request/accept
// (rd_*), read return (ret_*, shared ret_data), per-client write
// request/accept (wr_*); axi = AXI3 master bus. Reads are issued through a
// single AR register with one outstanding read per client (id = client);
// writes go through a single line buffer driven by a 4-state FSM. Reads that
// hit the line held in the write buffer wait until the write completes.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WORDS = 4,
  parameter int LINE_LSB   = $clog2(LINE_WORDS * 4)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             rd_req,
  input  logic [3*NUM_PORTS-1:0]           rd_type,
  input  logic [32*NUM_PORTS-1:0]          rd_addr,
  output logic [NUM_PORTS-1:0]             rd_rdy,
  output logic [NUM_PORTS-1:0]             ret_valid,
  output logic [NUM_PORTS-1:0]             ret_last,
  output logic [31:0]                      ret_data,
  input  logic [NUM_PORTS-1:0]             wr_req,
  input  logic [3*NUM_PORTS-1:0]           wr_type,
  input  logic [32*NUM_PORTS-1:0]          wr_addr,
  input  logic [4*NUM_PORTS-1:0]           wr_wstrb,
  input  logic [32*LINE_WORDS*NUM_PORTS-1:0] wr_data,
  output logic [NUM_PORTS-1:0]             wr_rdy,
  cache_axi_bridge_if.master               axi
);

  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LW_BITS = 32 * LINE_WORDS;

  // ---------------- read path ----------------
  logic [NUM_PORTS-1:0] outstanding_r;
  logic [NUM_PORTS-1:0] hazard_s;
  logic [NUM_PORTS-1:0] rd_elig_s;
  logic [NUM_PORTS-1:0] rd_grant_s;
  logic [PW-1:0]        rd_idx_s;
  logic                 rd_vld_s;
  logic [PW-1:0]        rr_rd_r;
  logic                 arvalid_r;
  logic [31:0]          araddr_r;
  logic [7:0]           arlen_r;
  logic [2:0]           arsize_r;
  logic [3:0]           arid_r;
  logic [2:0]           rd_sel_type_s;

  // ---------------- write path ----------------
  wstate_e              wstate_r;
  wstate_e              wstate_s;
  logic [NUM_PORTS-1:0] wr_elig_s;
  logic [NUM_PORTS-1:0] wr_grant_s;
  logic [PW-1:0]        wr_idx_s;
  logic                 wr_vld_s;
  logic [PW-1:0]        rr_wr_r;
  logic [31:0]          wbuf_addr_r;
  logic [2:0]           wbuf_type_r;
  logic [3:0]           wbuf_strb_r;
  logic [LW_BITS-1:0]   wbuf_data_r;
  logic [PW-1:0]        wbuf_id_r;
  logic [BEAT_W-1:0]    beat_r;
  logic [7:0]           wlen_s;
  logic                 awvalid_s;
  logic                 wvalid_s;
  logic                 wlast_s;
  logic                 bready_s;

  logic unused_s;
  assign unused_s = ^{axi.rresp, axi.bresp, axi.bid};

  // A client may compete for AR only if the AR slot is free, it has no read in
  // flight, and its line is not the one sitting in the write buffer.
  always_comb begin
    hazard_s  = '0;
    rd_elig_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hazard_s[i]  = (wstate_r != W_IDLE) &&
                     (rd_addr[32*i+LINE_LSB +: 32-LINE_LSB] == wbuf_addr_r[31:LINE_LSB]);
      rd_elig_s[i] = rd_req[i] & ~outstanding_r[i] & ~hazard_s[i] & ~arvalid_r & ~reset;
    end
  end

  rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_rd_arb (
    .req       (rd_elig_s),
    .ptr       (rr_rd_r),
    .grant     (rd_grant_s),
    .grant_idx (rd_idx_s),
    .grant_vld (rd_vld_s)
  );

  assign rd_rdy        = rd_grant_s;
  assign rd_sel_type_s = rd_type[3*rd_idx_s +: 3];

  // AR register, read pointer and per-client outstanding bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arvalid_r     <= 1'b0;
      araddr_r      <= 32'd0;
      arlen_r       <= 8'd0;
      arsize_r      <= 3'd0;
      arid_r        <= 4'd0;
      rr_rd_r       <= '0;
      outstanding_r <= '0;
    end else begin
      if (rd_vld_s) begin
        arvalid_r <= 1'b1;
        araddr_r  <= rd_addr[32*rd_idx_s +: 32];
        arlen_r   <= req_len(rd_sel_type_s, LINE_WORDS);
        arsize_r  <= req_size(rd_sel_type_s);
        arid_r    <= 4'(rd_idx_s);
        rr_rd_r   <= (rd_idx_s == PW'(NUM_PORTS - 1)) ? '0 : rd_idx_s + PW'(1);
      end else if (arvalid_r && axi.arready) begin
        arvalid_r <= 1'b0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rd_grant_s[i]) begin
          outstanding_r[i] <= 1'b1;
        end else if (axi.rvalid && axi.rlast && (axi.rid == 4'(i))) begin
          outstanding_r[i] <= 1'b0;
        end
      end
    end
  end

  // Read beats are steered to the client whose id matches rid.
  always_comb begin
    ret_valid = '0;
    ret_last  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (axi.rvalid && (axi.rid == 4'(i)) && !reset) begin
        ret_valid[i] = 1'b1;
        ret_last[i]  = axi.rlast;
      end else begin
        ret_valid[i] = 1'b0;
        ret_last[i]  = 1'b0;
      end
    end
  end

  assign ret_data = axi.rdata;

  // ---------------- write arbitration and buffer ----------------
  assign wr_elig_s = wr_req & {NUM_PORTS{(wstate_r == W_IDLE) && !reset}};

  rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_wr_arb (
    .req       (wr_elig_s),
    .ptr       (rr_wr_r),
    .grant     (wr_grant_s),
    .grant_idx (wr_idx_s),
    .grant_vld (wr_vld_s)
  );

  assign wr_rdy = wr_grant_s;

  // Write FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_r <= W_IDLE;
    end else begin
      wstate_r <= wstate_s;
    end
  end

  // Write FSM next-state logic.
  always_comb begin
    wstate_s = wstate_r;
    case (wstate_r)
      W_IDLE:  if (wr_vld_s)                 wstate_s = W_AW;   else wstate_s = W_IDLE;
      W_AW:    if (axi.awready)              wstate_s = W_DATA; else wstate_s = W_AW;
      W_DATA:  if (axi.wready && wlast_s)    wstate_s = W_RESP; else wstate_s = W_DATA;
      W_RESP:  if (axi.bvalid)               wstate_s = W_IDLE; else wstate_s = W_RESP;
      default: wstate_s = W_IDLE;
    endcase
  end

  // Write FSM outputs: channel valids/ready follow the state directly.
  always_comb begin
    awvalid_s = 1'b0;
    wvalid_s  = 1'b0;
    bready_s  = 1'b0;
    wlast_s   = 1'b0;
    case (wstate_r)
      W_AW:    awvalid_s = 1'b1;
      W_DATA: begin
        wvalid_s = 1'b1;
        wlast_s  = (8'(beat_r) == wlen_s);
      end
      W_RESP:  bready_s = 1'b1;
      default: begin
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
      end
    endcase
  end

  // Write buffer capture, write pointer and beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_wr_r     <= '0;
      wbuf_addr_r <= 32'd0;
      wbuf_type_r <= 3'd0;
      wbuf_strb_r <= 4'd0;
      wbuf_data_r <= '0;
      wbuf_id_r   <= '0;
      beat_r      <= '0;
    end else begin
      if (wr_vld_s) begin
        wbuf_addr_r <= wr_addr[32*wr_idx_s +: 32];
        wbuf_type_r <= wr_type[3*wr_idx_s +: 3];
        wbuf_strb_r <= wr_wstrb[4*wr_idx_s +: 4];
        wbuf_data_r <= wr_data[LW_BITS*wr_idx_s +: LW_BITS];
        wbuf_id_r   <= wr_idx_s;
        rr_wr_r     <= (wr_idx_s == PW'(NUM_PORTS - 1)) ? '0 : wr_idx_s + PW'(1);
      end
      if ((wstate_r == W_AW) && axi.awready) begin
        beat_r <= '0;
      end else if ((wstate_r == W_DATA) && axi.wready) begin
        beat_r <= beat_r + BEAT_W'(1);
      end
    end
  end

  assign wlen_s = req_len(wbuf_type_r, LINE_WORDS);

  // ---------------- AXI outputs ----------------
  assign axi.arid    = arid_r;
  assign axi.araddr  = araddr_r;
  assign axi.arlen   = arlen_r;
  assign axi.arsize  = arsize_r;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = arvalid_r;
  assign axi.rready  = 1'b1;

  assign axi.awid    = 4'(wbuf_id_r);
  assign axi.awaddr  = wbuf_addr_r;
  assign axi.awlen   = wlen_s;
  assign axi.awsize  = req_size(wbuf_type_r);
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = awvalid_s;

  assign axi.wid    = 4'(wbuf_id_r);
  assign axi.wdata  = wbuf_data_r[32*beat_r +: 32];
  assign axi.wstrb  = (wbuf_type_r == T_LINE) ? 4'hF : wbuf_strb_r;
  assign axi.wlast  = wlast_s;
  assign axi.wvalid = wvalid_s;
  assign axi.bready = bready_s;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge (NUM_PORTS=2, LINE_WORDS=4).
// Directed phases (reset, line read, word write, hazard) plus a randomized
// read phase checked against a transaction-level reference model.
module tb_cache_axi_bridge;

  localparam int NP = 2;
  localparam int LW = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NP-1:0]        rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy;
  logic [3*NP-1:0]      rd_type, wr_type;
  logic [32*NP-1:0]     rd_addr, wr_addr;
  logic [4*NP-1:0]      wr_wstrb;
  logic [32*LW*NP-1:0]  wr_data;
  logic [31:0]          ret_data;

  int errors = 0;
  int checks = 0;

  cache_axi_bridge_if axi();

  cache_axi_bridge #(.NUM_PORTS(NP), .LINE_WORDS(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .axi       (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rd_req = '0; rd_type = '0; rd_addr = '0;
    wr_req = '0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = 4'd0; axi.rdata = 32'd0;
    axi.rlast = 1'b0; axi.rresp = 2'd0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bid = 4'd0; axi.bresp = 2'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference decode: line = full burst of word beats, else one beat of type[1:0].
  function automatic logic [7:0] m_len(input logic [2:0] t);
    return (t == 3'd4) ? 8'(LW - 1) : 8'd0;
  endfunction
  function automatic logic [2:0] m_size(input logic [2:0] t);
    return (t == 3'd4) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] line [LW];
    logic [1:0]  exp_rdy, ev, el;
    logic [1:0]  m_busy;
    logic        m_ar_busy;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [3:0]  m_arid;
    int          m_ptr, c, k, sel, b, n;
    int          fl_id[$];
    int          fl_left[$];

    // ---- reset with requests held ----
    idle_inputs();
    reset = 1'b1;
    rd_req = 2'b11; wr_req = 2'b11;
    rd_type = {3'd4, 3'd2}; wr_type = {3'd4, 3'd2};
    rd_addr = {$urandom, $urandom}; wr_addr = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("reset_quiet", {rd_rdy, wr_rdy, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, ret_valid}, 64'd0);
      tick();
    end
    do_reset();

    // ---- line read from client 1 ----
    smp();
    chk("const_outs", {axi.rready, axi.arburst, axi.awburst, axi.arlock, axi.awlock,
                       axi.arcache, axi.awcache, axi.arprot, axi.awprot},
        {1'b1, 2'b01, 2'b01, 2'd0, 2'd0, 4'd0, 4'd0, 3'd0, 3'd0});
    tick();
    rd_req = 2'b10; rd_type[5:3] = 3'd4; rd_addr[63:32] = 32'h1FC00010;
    smp();
    chk("line_rd_rdy", rd_rdy, 2'b10);
    tick();
    rd_req = 2'b00; axi.arready = 1'b1;
    smp();
    chk("line_ar", {axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arid},
        {1'b1, 32'h1FC00010, 8'd3, 3'd2, 4'd1});
    tick();
    axi.arready = 1'b0;
    smp();
    chk("line_ar_done", axi.arvalid, 1'b0);
    for (int i = 0; i < LW; i++) begin
      tick();
      d = $urandom;
      rd_req = 2'b10;
      axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = d; axi.rlast = (i == LW - 1);
      smp();
      chk("line_beat", {ret_valid, ret_last, ret_data, rd_rdy},
          {2'b10, (i == LW - 1) ? 2'b10 : 2'b00, d, 2'b00});
    end
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    smp();
    chk("line_rd_reissue", rd_rdy, 2'b10);
    do_reset();

    // ---- randomized reads: round-robin, interleaved returns, AR backpressure ----
    m_busy = '0; m_ar_busy = 1'b0; m_ptr = 0;
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arid = '0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      tick();
      rd_req = 2'b11;
      for (int p = 0; p < NP; p++) begin
        rd_type[3*p +: 3]  = ($urandom_range(1, 0) == 1) ? 3'd4 : 3'd2;
        rd_addr[32*p +: 32] = $urandom & 32'hFFFF_FFFC;
      end
      axi.arready = ($urandom_range(1, 0) == 1);
      d = $urandom;
      sel = -1;
      if (fl_id.size() > 0 && $urandom_range(2, 0) != 0) begin
        k = $urandom_range(fl_id.size() - 1, 0);
        sel = k;
        axi.rvalid = 1'b1; axi.rid = 4'(fl_id[k]); axi.rdata = d;
        axi.rlast = (fl_left[k] == 1);
      end else begin
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
      end
      smp();
      exp_rdy = '0;
      if (!m_ar_busy) begin
        for (int off = 0; off < NP; off++) begin
          c = (m_ptr + off) % NP;
          if (exp_rdy == 2'b00 && rd_req[c] && !m_busy[c]) exp_rdy[c] = 1'b1;
        end
      end
      chk("rr_rdy", rd_rdy, exp_rdy);
      chk("ar_valid", axi.arvalid, m_ar_busy);
      if (m_ar_busy)
        chk("ar_payload", {axi.araddr, axi.arlen, axi.arsize, axi.arid},
            {m_araddr, m_arlen, m_arsize, m_arid});
      if (sel >= 0) begin
        ev = '0; el = '0;
        ev[fl_id[sel]] = 1'b1;
        if (fl_left[sel] == 1) el[fl_id[sel]] = 1'b1;
        chk("ret_route", {ret_valid, ret_last, ret_data}, {ev, el, d});
      end else begin
        chk("ret_idle", ret_valid, 2'b00);
      end
      // advance the model across the coming clock edge
      if (m_ar_busy && axi.arready) begin
        m_ar_busy = 1'b0;
        fl_id.push_back(int'(m_arid));
        fl_left.push_back(int'(m_arlen) + 1);
      end else if (exp_rdy != 2'b00) begin
        c = exp_rdy[1] ? 1 : 0;
        m_ar_busy = 1'b1;
        m_araddr  = rd_addr[32*c +: 32];
        m_arlen   = m_len(rd_type[3*c +: 3]);
        m_arsize  = m_size(rd_type[3*c +: 3]);
        m_arid    = 4'(c);
        m_busy[c] = 1'b1;
        m_ptr     = (c + 1) % NP;
      end
      if (sel >= 0) begin
        fl_left[sel] = fl_left[sel] - 1;
        if (fl_left[sel] == 0) begin
          m_busy[fl_id[sel]] = 1'b0;
          fl_id.delete(sel);
          fl_left.delete(sel);
        end
      end
    end
    do_reset();

    // ---- word write with AW/W backpressure ----
    wr_req = 2'b01; wr_type[2:0] = 3'd2; wr_addr[31:0] = 32'h80001004;
    wr_wstrb[3:0] = 4'b0011; wr_data[31:0] = 32'hDEADBEEF;
    wr_data[127:32] = {$urandom, $urandom, $urandom};
    smp();
    chk("wr_rdy", wr_rdy, 2'b01);
    tick();
    wr_req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("aw_hold", {axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awid, axi.wvalid, axi.bready},
          {1'b1, 32'h80001004, 8'd0, 3'd2, 4'd0, 1'b0, 1'b0});
      tick();
    end
    axi.awready = 1'b1;
    smp();
    chk("aw_hs", axi.awvalid, 1'b1);
    tick();
    axi.awready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      axi.wready = (i == 5);
      smp();
      chk("w_hold", {axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, axi.wid, axi.awvalid, axi.bready},
          {1'b1, 32'hDEADBEEF, 4'b0011, 1'b1, 4'd0, 1'b0, 1'b0});
      tick();
    end
    axi.wready = 1'b0;
    wr_req = 2'b01;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("w_resp", {axi.bready, axi.wvalid, wr_rdy}, {1'b1, 1'b0, 2'b00});
      tick();
    end
    axi.bvalid = 1'b1;
    smp();
    chk("b_hs", {axi.bready, wr_rdy}, {1'b1, 2'b00});
    tick();
    axi.bvalid = 1'b0;
    smp();
    chk("wr_next", {axi.bready, wr_rdy}, {1'b0, 2'b01});
    do_reset();

    // ---- line write with read-after-write hazard ----
    for (int i = 0; i < LW; i++) line[i] = $urandom;
    wr_req = 2'b01; wr_type[2:0] = 3'd4; wr_addr[31:0] = 32'h80002000;
    wr_wstrb[3:0] = 4'($urandom_range(14, 0));
    for (int i = 0; i < LW; i++) wr_data[32*i +: 32] = line[i];
    smp();
    chk("haz_wr_rdy", wr_rdy, 2'b01);
    tick();
    wr_req = 2'b00;
    rd_req = 2'b10; rd_type[5:3] = 3'd2; rd_addr[63:32] = 32'h80002008;
    smp();
    chk("haz_blocked", {rd_rdy, axi.awvalid, axi.awaddr, axi.awlen, axi.awsize},
        {2'b00, 1'b1, 32'h80002000, 8'd3, 3'd2});
    tick();
    rd_req = 2'b11; rd_type[2:0] = 3'd2; rd_addr[31:0] = 32'h80003000;
    smp();
    chk("haz_other_ok", rd_rdy, 2'b01);
    tick();
    rd_req = 2'b10; axi.arready = 1'b1;
    smp();
    chk("haz_ar", {axi.arvalid, axi.araddr, axi.arid, rd_rdy}, {1'b1, 32'h80003000, 4'd0, 2'b00});
    tick();
    axi.arready = 1'b0; axi.awready = 1'b1;
    smp();
    chk("haz_aw", {rd_rdy, axi.awvalid}, {2'b00, 1'b1});
    tick();
    axi.awready = 1'b0;
    b = 0; n = 0;
    while (b < LW && n < 60) begin
      axi.wready = ($urandom_range(1, 0) == 1);
      smp();
      chk("haz_w", {axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, rd_rdy},
          {1'b1, line[b], 4'hF, (b == LW - 1), 2'b00});
      if (axi.wready) b++;
      n++;
      tick();
    end
    chk("haz_w_beats", 64'(b), 64'(LW));
    axi.wready = 1'b0;
    smp();
    chk("haz_resp", {axi.bready, axi.wvalid, rd_rdy}, {1'b1, 1'b0, 2'b00});
    tick();
    axi.bvalid = 1'b1;
    smp();
    chk("haz_bvalid", {axi.bready, rd_rdy}, {1'b1, 2'b00});
    tick();
    axi.bvalid = 1'b0;
    smp();
    chk("haz_release", {axi.bready, rd_rdy}, {1'b0, 2'b10});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
